// File: rtl/seg7_capture.sv
// Seven-segment display capture: samples eight active-low HEX digits, waits for the
// bus to settle, decodes it and hands each new settled value to a valid/ready consumer.
module seg7_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int REPORT_REPEATS = 0
) (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic [6:0]  HEX0,
  input  logic [6:0]  HEX1,
  input  logic [6:0]  HEX2,
  input  logic [6:0]  HEX3,
  input  logic [6:0]  HEX4,
  input  logic [6:0]  HEX5,
  input  logic [6:0]  HEX6,
  input  logic [6:0]  HEX7,
  output logic [31:0] out_data,
  output logic [7:0]  out_bad,
  output logic        out_valid,
  input  logic        out_ready
);

  // Handshake: a report is transferred on a rising edge where out_valid and out_ready
  // are both 1; out_valid/out_data/out_bad stay frozen until then, out_ready alone is ignored.

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic {IDLE, REPORT} state_t;

  state_t       state_q, state_d;
  logic [55:0]  samp_q, samp_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [31:0]  out_data_q, out_data_d;
  logic [7:0]   out_bad_q, out_bad_d;
  logic         out_valid_q, out_valid_d;
  logic [39:0]  last_acc_q, last_acc_d;
  logic         accepted_q, accepted_d;
  logic         dirty_q, dirty_d;

  logic [55:0]  hex_bus;
  logic [31:0]  dec_data;
  logic [7:0]   dec_bad;
  logic         changed;
  logic         settled;
  logic         report_cond;

  // Returns {bad, nibble}; unknown patterns decode as bad with a zero nibble.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  assign hex_bus = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always_comb begin
    dec_data = '0;
    dec_bad  = '0;
    for (int i = 0; i < 8; i++) begin
      logic [4:0] d;
      d = seg_decode(samp_q[7*i +: 7]);
      dec_data[4*i +: 4] = d[3:0];
      dec_bad[i]         = d[4];
    end
  end

  assign changed = (hex_bus != samp_q);
  assign settled = (cnt_q == STABLE);

  always_comb begin
    samp_d = hex_bus;
    if (changed)             cnt_d = '0;
    else if (cnt_q == STABLE) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 8'd1;
  end

  // Repeat mode: any instability since the last acceptance re-arms a report of the same value.
  assign report_cond = ({dec_data, dec_bad} != last_acc_q) || !accepted_q ||
                       ((REPORT_REPEATS != 0) && dirty_q);

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_bad_d   = out_bad_q;
    out_valid_d = out_valid_q;
    last_acc_d  = last_acc_q;
    accepted_d  = accepted_q;
    dirty_d     = dirty_q | changed;
    case (state_q)
      IDLE: begin
        if (settled && report_cond) begin
          out_data_d  = dec_data;
          out_bad_d   = dec_bad;
          out_valid_d = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (out_ready) begin
          last_acc_d  = {out_data_q, out_bad_q};
          accepted_d  = 1'b1;
          out_valid_d = 1'b0;
          dirty_d     = changed;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      samp_q      <= '1;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_bad_q   <= '0;
      out_valid_q <= 1'b0;
      last_acc_q  <= '0;
      accepted_q  <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_bad_q   <= out_bad_d;
      out_valid_q <= out_valid_d;
      last_acc_q  <= last_acc_d;
      accepted_q  <= accepted_d;
      dirty_q     <= dirty_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_bad   = out_bad_q;
  assign out_valid = out_valid_q;

endmodule
